// File: rtl/tick_seq_pkg.sv
// Shared state type, minimum duration and clamp helper
// for the tick sequencer and its duration timer.
package tick_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } seq_state_t;

    localparam int MIN_DUR = 1;

    function automatic logic [31:0] clamp_dur(input logic [31:0] d);
        return (d == '0) ? 32'(MIN_DUR) : d;
    endfunction

endpackage

// File: rtl/dur_timer.sv
// Down-counter for phase durations: loads a length,
// counts down to 1 and holds there; done while value is 1.
module dur_timer
    import tick_seq_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          clr,
    output logic          done
);

    logic [CW-1:0] value_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (clr) begin
            value_q <= '0;
        end else if (value_q > CW'(MIN_DUR)) begin
            value_q <= value_q - CW'(1);
        end
    end

    assign done = (value_q == CW'(MIN_DUR));

endmodule

// File: rtl/tick_sequencer.sv
// Programmable low/high tick generator with a one-deep
// config slot and a wrapping 2-bit tick counter.
module tick_sequencer
    import tick_seq_pkg::*;
#(
    parameter int CW       = 8,
    parameter int DEF_LOW  = 4,
    parameter int DEF_HIGH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_low,
    input  logic [CW-1:0] cfg_high,
    input  logic          start,
    input  logic          stop,
    output logic          tick,
    output logic [1:0]    cnt,
    output logic          wrap,
    output logic          busy
);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] act_low_q, act_high_q;
    logic [CW-1:0] pend_low_q, pend_high_q;
    logic          pend_full_q;
    logic [1:0]    cnt_q;
    logic          wrap_q;

    logic          tmr_load, tmr_clr, tmr_done;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] low_eff, pend_low_c, pend_high_c;
    logic          cnt_inc, hl_edge, apply, xfer;

    assign pend_low_c  = CW'(clamp_dur(32'(pend_low_q)));
    assign pend_high_c = CW'(clamp_dur(32'(pend_high_q)));

    // A pending config takes effect for the LOW phase it opens.
    assign low_eff = pend_full_q ? pend_low_c : act_low_q;

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_clr  = 1'b0;
        tmr_val  = act_low_q;
        cnt_inc  = 1'b0;
        hl_edge  = 1'b0;
        if (stop) begin
            state_d = IDLE;
            tmr_clr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = low_eff;
                    end
                end
                LOW: begin
                    if (tmr_done) begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = act_high_q;
                        cnt_inc  = 1'b1;
                    end
                end
                HIGH: begin
                    if (tmr_done) begin
                        state_d  = LOW;
                        tmr_load = 1'b1;
                        tmr_val  = low_eff;
                        hl_edge  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign apply = pend_full_q & ((state_q == IDLE) | hl_edge);
    assign xfer  = cfg_valid & ~pend_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            act_low_q   <= CW'(clamp_dur(32'(DEF_LOW)));
            act_high_q  <= CW'(clamp_dur(32'(DEF_HIGH)));
            pend_low_q  <= '0;
            pend_high_q <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            wrap_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= cnt_inc & (cnt_q == 2'd3);
            if (cnt_inc) begin
                cnt_q <= cnt_q + 2'd1;
            end
            if (apply) begin
                act_low_q   <= pend_low_c;
                act_high_q  <= pend_high_c;
                pend_full_q <= 1'b0;
            end else if (xfer) begin
                pend_low_q  <= cfg_low;
                pend_high_q <= cfg_high;
                pend_full_q <= 1'b1;
            end
        end
    end

    dur_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clr      (tmr_clr),
        .done     (tmr_done)
    );

    assign tick      = (state_q == HIGH);
    assign busy      = (state_q != IDLE);
    assign cnt       = cnt_q;
    assign wrap      = wrap_q;
    assign cfg_ready = ~pend_full_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Scoreboard bench for tick_sequencer: a schedule-based model
// predicts every cycle's outputs; a monitor compares them.
module tb_tick_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_low = '0;
    logic [CW-1:0] cfg_high = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          tick;
    logic [1:0]    cnt;
    logic          wrap;
    logic          busy;

    int total = 0;
    int bad = 0;

    tick_sequencer #(.CW(CW), .DEF_LOW(4), .DEF_HIGH(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_low   (cfg_low),
        .cfg_high  (cfg_high),
        .start     (start),
        .stop      (stop),
        .tick      (tick),
        .cnt       (cnt),
        .wrap      (wrap),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model: running flag, phase kind and the absolute edge
    // number at which the current phase ends.
    int  cyc = 0;
    bit  m_run, m_high, m_pf, m_wrap, m_idle, m_hl, m_xfer;
    int  m_end, m_cnt, m_al, m_ah, m_pl, m_ph;
    logic [5:0] exp_q[$];

    function automatic int cl(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_high = 0; m_pf = 0; m_wrap = 0;
            m_cnt = 0; m_al = 4; m_ah = 1; m_end = 0;
        end else begin
            m_xfer = cfg_valid && !m_pf;
            m_idle = !m_run;
            m_hl   = m_run && m_high && (cyc == m_end) && !stop;
            m_wrap = 0;
            if (m_pf && (m_idle || m_hl)) begin
                m_al = cl(m_pl);
                m_ah = cl(m_ph);
                m_pf = 0;
            end
            if (stop) begin
                m_run = 0;
                m_high = 0;
            end else if (m_idle) begin
                if (start) begin
                    m_run = 1;
                    m_high = 0;
                    m_end = cyc + m_al;
                end
            end else if (cyc == m_end) begin
                if (!m_high) begin
                    m_high = 1;
                    m_end = cyc + m_ah;
                    m_cnt = (m_cnt + 1) % 4;
                    m_wrap = (m_cnt == 0);
                end else begin
                    m_high = 0;
                    m_end = cyc + m_al;
                end
            end
            if (m_xfer) begin
                m_pf = 1;
                m_pl = int'(cfg_low);
                m_ph = int'(cfg_high);
            end
        end
        exp_q.push_back({m_high, 2'(m_cnt), m_wrap, m_run, !m_pf});
        cyc++;
    end

    logic [5:0] got, want;
    always @(negedge clk) begin
        total++;
        got = {tick, cnt, wrap, busy, cfg_ready};
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty t=%0t got=%b want=<none>", $time, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                bad++;
                $display("FAIL sb cyc=%0d tick/cnt/wrap/busy/rdy got=%b want=%b",
                         cyc, got, want);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input int l, input int h);
        int n = 0;
        cfg_valid = 1'b1;
        cfg_low = CW'(l);
        cfg_high = CW'(h);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cfg_accept_timeout", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic start_measure(input string nm, input int want_n);
        int n = 0;
        start = 1'b1;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!tick && n < 100);
        chk(nm, n, want_n);
    endtask

    task automatic stop_now();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        int n;
        bit acc;
        #1;
        chk("rst_tick", int'(tick), 0);
        chk("rst_cnt", int'(cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        cycles(2);
        reset = 1'b0;

        // defaults 4/1: first tick 5 cycles after start
        start_measure("t1_first_tick", 5);
        cycles(22);
        stop_now();
        cycles(2);

        // 8/2 configured in IDLE
        send_cfg(8, 2);
        cycles(2);
        start_measure("t2_first_tick", 9);
        cycles(25);
        stop_now();

        // reconfigure mid-LOW, second request held off
        send_cfg(4, 1);
        cycles(2);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        cycles(1);
        send_cfg(1, 1);
        send_cfg(3, 2);
        cycles(20);
        stop_now();

        // zero durations behave as 1/1
        send_cfg(0, 0);
        cycles(2);
        start_measure("t4_first_tick", 2);
        cycles(10);
        stop_now();

        // start and stop together stay idle
        start = 1'b1;
        stop = 1'b1;
        cycles(1);
        start = 1'b0;
        stop = 1'b0;
        chk("t5_start_stop_busy", int'(busy), 0);
        send_cfg(3, 3);
        cycles(2);
        start_measure("t5_first_tick", 4);
        cycles(1);
        stop_now();
        chk("t5_stop_high_tick", int'(tick), 0);
        cycles(3);

        // async reset mid-HIGH with cnt=2
        send_cfg(4, 1);
        cycles(1);
        stop_now();
        cycles(1);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        n = 0;
        while (!(tick && cnt == 2'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_cnt2", int'(tick && cnt == 2'd2), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_tick", int'(tick), 0);
        chk("t6_async_cnt", int'(cnt), 0);
        chk("t6_async_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        cycles(2);

        // randomized traffic
        acc = 0;
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom % 8 == 0);
            stop = ($urandom % 40 == 0);
            if (!(cfg_valid && !acc)) begin
                cfg_valid = ($urandom % 6 == 0);
                cfg_low = CW'($urandom % 6);
                cfg_high = CW'($urandom % 4);
            end
            acc = cfg_valid && cfg_ready;
        end
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        cfg_valid = 1'b0;
        cycles(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
